// File: rtl/muldiv_issue_ctrl.sv
// muldiv_issue_ctrl: dual-lane issue arbiter, iterative WIDTH-cycle mult/multu sequencer and HI/LO interlock stalls
// Ports: clk, reset (sync, active-high), flush aborts the in-flight op and blocks grants;
//   lane 0 (older) req0_valid/req0_sign/req0_a/req0_b/rd0, lane 1 (younger) req1_*/rd1;
//   grant0/grant1, stall0/stall1 combinational; hi/lo architectural result, busy while running,
//   done one-cycle pulse when a new hi/lo first becomes visible.
module muldiv_issue_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             req0_valid,
  input  logic             req0_sign,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             rd0,
  input  logic             req1_valid,
  input  logic             req1_sign,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             rd1,
  output logic             grant0,
  output logic             grant1,
  output logic             stall0,
  output logic             stall1,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state;
  logic [WIDTH-1:0] count, mplier, selA, selB, magA, magB;
  logic [2*WIDTH-1:0] mcand, acc, accNext, prodFinal;
  logic negate, nidle, selSign;
  always_comb begin
    nidle = state != IDLE;
    stall0 = (req0_valid | rd0) & nidle;
    // lane 1 also waits behind lane 0's same-cycle multiply: structural and HI/LO RAW in one term
    stall1 = stall0 | ((req1_valid | rd1) & (nidle | req0_valid));
    grant0 = req0_valid & ~stall0 & ~flush & ~reset;
    grant1 = req1_valid & ~stall1 & ~flush & ~reset;
    selA = grant0 ? req0_a : req1_a;
    selB = grant0 ? req0_b : req1_b;
    selSign = grant0 ? req0_sign : req1_sign;
    magA = (selSign & selA[WIDTH-1]) ? -selA : selA;
    magB = (selSign & selB[WIDTH-1]) ? -selB : selB;
    // the last multiplier bit is folded in on the commit edge itself
    accNext = acc + (mplier[0] ? mcand : '0);
    prodFinal = negate ? -accNext : accNext;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      count <= '0;
      hi <= '0;
      lo <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      acc <= '0;
      mcand <= '0;
      mplier <= '0;
      negate <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (grant0 | grant1) begin
          state <= RUN;
          busy <= 1'b1;
          count <= WIDTH'(WIDTH - 1);
          acc <= '0;
          mcand <= {{WIDTH{1'b0}}, magA};
          mplier <= magB;
          negate <= selSign & (selA[WIDTH-1] ^ selB[WIDTH-1]);
        end
      end else if (flush) begin
        state <= IDLE;
        busy <= 1'b0;
      end else if (count == '0) begin
        state <= IDLE;
        busy <= 1'b0;
        {hi, lo} <= prodFinal;
        done <= 1'b1;
      end else begin
        count <= count - 1'b1;
        acc <= accNext;
        mcand <= mcand << 1;
        mplier <= mplier >> 1;
      end
    end
  end
endmodule

// File: tb/tb_muldiv_issue_ctrl.sv
// tb_muldiv_issue_ctrl: table, directed and random checks of muldiv_issue_ctrl against a cycle-level model
module tb_muldiv_issue_ctrl;
  localparam int W = 32;
  logic clk, reset, flush;
  logic req0_valid, req0_sign, rd0, req1_valid, req1_sign, rd1;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b, hi, lo;
  logic grant0, grant1, stall0, stall1, busy, done;
  int vectors = 0, miscompares = 0;
  int mRem = 0;
  logic [2*W-1:0] mPend = '0;
  logic [W-1:0] mHi = '0, mLo = '0;
  logic mDone = 1'b0;
  logic sg0, sg1, sst0, sst1;
  typedef struct {
    logic sign;
    logic [W-1:0] a, b, eh, el;
  } vec_t;
  vec_t tbl[5];

  muldiv_issue_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .req0_valid(req0_valid), .req0_sign(req0_sign), .req0_a(req0_a), .req0_b(req0_b), .rd0(rd0),
    .req1_valid(req1_valid), .req1_sign(req1_sign), .req1_a(req1_a), .req1_b(req1_b), .rd1(rd1),
    .grant0(grant0), .grant1(grant1), .stall0(stall0), .stall1(stall1),
    .hi(hi), .lo(lo), .busy(busy), .done(done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [2*W-1:0] mul(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
    longint sa, sb;
    sa = s ? longint'($signed(a)) : longint'({32'b0, a});
    sb = s ? longint'($signed(b)) : longint'({32'b0, b});
    return 64'(sa * sb);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic idle_in();
    {flush, req0_valid, req0_sign, rd0, req1_valid, req1_sign, rd1} = '0;
    {req0_a, req0_b, req1_a, req1_b} = '0;
  endtask

  // one cycle: check combinational outputs, clock, advance model, check registered outputs
  task automatic step();
    logic nid, es0, es1, eg0, eg1;
    logic [2*W-1:0] p;
    #2;
    nid = mRem != 0;
    es0 = (req0_valid | rd0) & nid;
    es1 = es0 | ((req1_valid | rd1) & (nid | req0_valid));
    eg0 = req0_valid & !es0 & !flush & !reset;
    eg1 = req1_valid & !es1 & !flush & !reset;
    chk("grant0", 64'(grant0), 64'(eg0));
    chk("grant1", 64'(grant1), 64'(eg1));
    chk("stall0", 64'(stall0), 64'(es0));
    chk("stall1", 64'(stall1), 64'(es1));
    {sg0, sg1, sst0, sst1} = {grant0, grant1, stall0, stall1};
    p = eg0 ? mul(req0_sign, req0_a, req0_b) : mul(req1_sign, req1_a, req1_b);
    @(posedge clk);
    if (reset) begin
      mRem = 0; mHi = '0; mLo = '0; mDone = 1'b0;
    end else begin
      mDone = 1'b0;
      if (mRem != 0) begin
        if (flush) mRem = 0;
        else if (mRem == 1) begin
          {mHi, mLo} = mPend; mDone = 1'b1; mRem = 0;
        end else mRem--;
      end else if (eg0 | eg1) begin
        mRem = W; mPend = p;
      end
    end
    #1;
    chk("busy", 64'(busy), 64'(mRem != 0));
    chk("done", 64'(done), 64'(mDone));
    chk("hi", 64'(hi), 64'(mHi));
    chk("lo", 64'(lo), 64'(mLo));
  endtask

  function automatic logic [W-1:0] rnd();
    case ($urandom_range(0, 4))
      0: return 32'h8000_0000;
      1: return 32'hFFFF_FFFF;
      2: return W'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int bcnt, dcnt;
    logic [W-1:0] ph, pl;
    tbl[0] = '{1'b0, 32'd7, 32'd6, 32'h0000_0000, 32'h0000_002A};
    tbl[1] = '{1'b1, -32'sd3, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1};
    tbl[2] = '{1'b1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
    tbl[3] = '{1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    tbl[4] = '{1'b1, -32'sd7, -32'sd9, 32'h0000_0000, 32'h0000_003F};
    idle_in();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    chk("reset_hi", 64'(hi), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);

    // table: each product issued on lane 0, busy counted, result checked in the done cycle
    for (int i = 0; i < 5; i++) begin
      req0_valid = 1'b1; req0_sign = tbl[i].sign; req0_a = tbl[i].a; req0_b = tbl[i].b;
      step();
      chk("tbl_grant", 64'(sg0), 64'd1);
      idle_in();
      bcnt = 0;
      for (int k = 0; k < W; k++) begin
        bcnt += int'(busy);
        step();
      end
      chk("tbl_busy_cycles", 64'(bcnt), 64'(W));
      chk("tbl_done", 64'(done), 64'd1);
      chk("tbl_hi", 64'(hi), 64'(tbl[i].eh));
      chk("tbl_lo", 64'(lo), 64'(tbl[i].el));
    end

    // arbitration: both lanes in IDLE; lane 1 held, then granted in lane 0's done cycle
    req0_valid = 1'b1; req0_a = 32'd3; req0_b = 32'd4;
    req1_valid = 1'b1; req1_a = 32'd5; req1_b = 32'd6;
    step();
    chk("arb_grant0", 64'(sg0), 64'd1);
    chk("arb_stall1", 64'(sst1), 64'd1);
    req0_valid = 1'b0;
    for (int k = 0; k < W; k++) step();
    chk("arb_done0_lo", 64'(lo), 64'd12);
    step();
    chk("arb_grant1_in_done", 64'(sg1), 64'd1);
    idle_in();
    for (int k = 0; k < W; k++) step();
    chk("arb_done1_lo", 64'(lo), 64'd30);

    // HI/LO RAW: mult with rd1, then rd0 held through busy, then rd0 with req1 unstalled
    req0_valid = 1'b1; req0_a = 32'd11; req0_b = 32'd13; rd1 = 1'b1;
    step();
    chk("raw_stall1", 64'(sst1), 64'd1);
    idle_in();
    rd0 = 1'b1;
    dcnt = 0;
    for (int k = 0; k < W; k++) begin
      step();
      dcnt += int'(sst0);
    end
    chk("raw_stall0_cycles", 64'(dcnt), 64'(W));
    req1_valid = 1'b1; req1_a = 32'd2; req1_b = 32'd2;
    step();
    chk("raw_rd0_released", 64'(sst0), 64'd0);
    chk("raw_rd0_lo", 64'(lo), 64'd143);
    chk("raw_rd0_req1_nostall", 64'(sst1), 64'd0);
    idle_in();
    for (int k = 0; k < W; k++) step();
    chk("raw_lane1_lo", 64'(lo), 64'd4);

    // flush in the 10th RUN cycle
    ph = hi; pl = lo;
    req0_valid = 1'b1; req0_a = 32'd1000; req0_b = 32'd1000;
    step();
    idle_in();
    for (int k = 0; k < 9; k++) step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_busy", 64'(busy), 64'd0);
    dcnt = 0;
    for (int k = 0; k < 40; k++) begin
      step();
      dcnt += int'(done);
    end
    chk("flush_no_done", 64'(dcnt), 64'd0);
    chk("flush_hi_kept", 64'({hi, lo}), 64'({ph, pl}));

    // reset mid-RUN with a request held
    req0_valid = 1'b1; req0_sign = 1'b1; req0_a = -32'sd5; req0_b = 32'd9;
    step();
    for (int k = 0; k < 5; k++) step();
    reset = 1'b1;
    step();
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_hilo", 64'({hi, lo}), 64'd0);
    step();
    chk("rst_no_grant", 64'({sg0, sg1}), 64'd0);
    reset = 1'b0;
    idle_in();
    step();

    // random traffic against the model
    for (int n = 0; n < 4000; n++) begin
      reset = ($urandom_range(0, 299) == 0);
      flush = ($urandom_range(0, 59) == 0);
      req0_valid = ($urandom_range(0, 3) == 0); req0_sign = $urandom_range(0, 1);
      req0_a = rnd(); req0_b = rnd(); rd0 = ($urandom_range(0, 5) == 0);
      req1_valid = ($urandom_range(0, 3) == 0); req1_sign = $urandom_range(0, 1);
      req1_a = rnd(); req1_b = rnd(); rd1 = ($urandom_range(0, 5) == 0);
      step();
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
